// File: rtl/trace_replay_driver.sv
// trace_replay_driver: stores a trace of timestamped input events and replays
// them as one-cycle strobes. Optional wrap-around replay under TRACE_REPLAY_LOOP_EN.
module trace_replay_driver #(
  parameter  int N_IN    = 3,
  parameter  int DATA_W  = 64,
  parameter  int TS_W    = 16,
  parameter  int DEPTH   = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int ENTRY_W = TS_W + N_IN + N_IN*DATA_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic                     i_wr_en,
  input  logic [ENTRY_W-1:0]       i_wr_data,
  output logic                     o_wr_full,
  output logic                     o_wr_err,
  input  logic                     i_start,
  input  logic                     i_abort,
`ifdef TRACE_REPLAY_LOOP_EN
  input  logic                     i_loop,
`endif
  output logic                     o_busy,
  output logic                     o_done,
  output logic [AW:0]              o_count,
  output logic [AW-1:0]            o_evt_idx,
  output logic [N_IN-1:0]          o_new_input,
  output logic [N_IN*DATA_W-1:0]   o_input_data
);

  localparam logic [1:0]      S_IDLE    = 2'd0;
  localparam logic [1:0]      S_WAIT    = 2'd1;
  localparam logic [1:0]      S_FIRE    = 2'd2;
  localparam logic [AW:0]     L_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]     L_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]   L_IDX_ONE = AW'(1);
  localparam logic [TS_W-1:0] L_TS_ONE  = TS_W'(1);

  logic [ENTRY_W-1:0]       r_mem [DEPTH];
  logic [1:0]               r_state;
  logic [TS_W-1:0]          r_gap;
  logic [AW-1:0]            r_idx;
  logic [AW:0]              r_count;
  logic                     r_full;
  logic                     r_err;
  logic                     r_busy;
  logic                     r_done;
  logic [N_IN-1:0]          r_new_input;
  logic [N_IN*DATA_W-1:0]   r_input_data;

  logic                     w_last;
  logic                     w_loop;
  logic [AW-1:0]            w_tgt_idx;
  logic [AW-1:0]            w_rd_idx;
  logic [ENTRY_W-1:0]       w_rd_entry;
  logic [TS_W-1:0]          w_rd_delta;
  logic [N_IN-1:0]          w_rd_mask;
  logic [N_IN*DATA_W-1:0]   w_lanes;
  logic [1:0]               w_state_nx;
  logic [TS_W-1:0]          w_gap_nx;
  logic [AW-1:0]            w_idx_nx;
  logic [AW:0]              w_count_nx;
  logic                     w_we;
  logic                     w_err_nx;
  logic                     w_done_nx;
  logic                     w_fire_nx;

`ifdef TRACE_REPLAY_LOOP_EN
  assign w_loop = i_loop;
`else
  assign w_loop = 1'b0;
`endif

  // The entry after the last one is entry 0, which is what a looping replay wants.
  assign w_last    = ({1'b0, r_idx} == (r_count - L_CNT_ONE));
  assign w_tgt_idx = w_last ? {AW{1'b0}} : (r_idx + L_IDX_ONE);

  // Read port: entry 0 for start, pending entry in WAIT, following entry in FIRE.
  always_comb begin
    w_rd_idx = {AW{1'b0}};
    case (r_state)
      S_WAIT:  w_rd_idx = r_idx;
      S_FIRE:  w_rd_idx = w_tgt_idx;
      default: w_rd_idx = {AW{1'b0}};
    endcase
  end

  assign w_rd_entry = r_mem[w_rd_idx];
  assign w_rd_delta = w_rd_entry[TS_W-1:0];
  assign w_rd_mask  = w_rd_entry[TS_W +: N_IN];

  // Masked lanes of the entry being read; unmasked lanes read zero.
  always_comb begin
    w_lanes = {(N_IN*DATA_W){1'b0}};
    for (int k = 0; k < N_IN; k++) begin
      if (w_rd_mask[k]) begin
        w_lanes[k*DATA_W +: DATA_W] = w_rd_entry[TS_W + N_IN + k*DATA_W +: DATA_W];
      end else begin
        w_lanes[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end
    end
  end

  // Next-state logic for the loader and the replay FSM.
  always_comb begin
    w_state_nx = r_state;
    w_gap_nx   = r_gap;
    w_idx_nx   = r_idx;
    w_count_nx = r_count;
    w_we       = 1'b0;
    w_err_nx   = 1'b0;
    w_done_nx  = 1'b0;
    w_fire_nx  = 1'b0;
    if (i_en) begin
      case (r_state)
        S_IDLE: begin
          if (i_clr) begin
            w_count_nx = {(AW+1){1'b0}};
          end else if (i_wr_en) begin
            if (r_count == L_DEPTH) begin
              w_err_nx = 1'b1;
            end else begin
              w_we       = 1'b1;
              w_count_nx = r_count + L_CNT_ONE;
            end
          end else begin
            w_count_nx = r_count;
          end
          if (i_start && !i_abort) begin
            if (r_count == {(AW+1){1'b0}}) begin
              w_done_nx = 1'b1;
            end else begin
              w_state_nx = S_WAIT;
              w_idx_nx   = {AW{1'b0}};
              w_gap_nx   = w_rd_delta;
            end
          end else begin
            w_state_nx = S_IDLE;
          end
        end
        S_WAIT: begin
          w_err_nx = i_wr_en;
          if (r_gap == {TS_W{1'b0}}) begin
            w_state_nx = S_FIRE;
            w_fire_nx  = 1'b1;
          end else begin
            w_gap_nx = r_gap - L_TS_ONE;
          end
        end
        S_FIRE: begin
          w_err_nx = i_wr_en;
          if (w_last && !w_loop) begin
            w_state_nx = S_IDLE;
            w_done_nx  = 1'b1;
          end else begin
            w_idx_nx = w_tgt_idx;
            // The FIRE cycle itself is one of the delta cycles, hence the minus one.
            if (w_rd_delta == {TS_W{1'b0}}) begin
              w_state_nx = S_FIRE;
              w_fire_nx  = 1'b1;
            end else begin
              w_state_nx = S_WAIT;
              w_gap_nx   = w_rd_delta - L_TS_ONE;
            end
          end
        end
        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
      if (i_abort) begin
        w_state_nx = S_IDLE;
        w_idx_nx   = {AW{1'b0}};
        w_fire_nx  = 1'b0;
        w_done_nx  = 1'b0;
      end else begin
        w_fire_nx = w_fire_nx;
      end
    end else begin
      w_state_nx = r_state;
    end
  end

  // Registered state and outputs; strobes clear immediately on reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_gap        <= {TS_W{1'b0}};
      r_idx        <= {AW{1'b0}};
      r_count      <= {(AW+1){1'b0}};
      r_full       <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_new_input  <= {N_IN{1'b0}};
      r_input_data <= {(N_IN*DATA_W){1'b0}};
    end else begin
      r_state      <= w_state_nx;
      r_gap        <= w_gap_nx;
      r_idx        <= w_idx_nx;
      r_count      <= w_count_nx;
      r_full       <= (w_count_nx == L_DEPTH);
      r_err        <= w_err_nx;
      r_busy       <= (w_state_nx != S_IDLE);
      r_done       <= w_done_nx;
      r_new_input  <= w_fire_nx ? w_rd_mask : {N_IN{1'b0}};
      r_input_data <= w_fire_nx ? w_lanes : {(N_IN*DATA_W){1'b0}};
    end
  end

  // Trace storage; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[r_count[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_wr_full    = r_full;
  assign o_wr_err     = r_err;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_count      = r_count;
  assign o_evt_idx    = r_idx;
  assign o_new_input  = r_new_input;
  assign o_input_data = r_input_data;

endmodule

// File: doc/trace_replay_driver.md
# trace_replay_driver

Parametrised stimulus engine for RTLola monitor benches and on-board self-test. It stores a trace of timestamped input events in local memory, then replays them onto N_IN monitor input channels. Each event drives a one-cycle `new_input` strobe with its data, and all data lines read zero outside strobes. It sits between a loader (bench or host bus) and the monitor `topEntity` input ports, and replaces hand-written per-event stimulus sequences.

## Interface
Parameters:
- N_IN, 3, number of monitor input channels
- DATA_W, 64, width of each channel value (signed, passed through unmodified)
- TS_W, 16, width of the per-event delay field in cycles
- DEPTH, 16, trace entries; power of two, ≥2
- Derived: AW = log2(DEPTH); ENTRY_W = TS_W + N_IN + N_IN*DATA_W

Entry layout, LSB first: delta[TS_W], mask[N_IN], value0..value(N_IN-1)[DATA_W each].

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  clock enable; 0 freezes all state
- clr  in  1  empties the trace (count←0); ignored while busy
- wr_en  in  1  append wr_data at index count
- wr_data  in  ENTRY_W  trace entry
- wr_full  out  1  count == DEPTH
- wr_err  out  1  one-cycle pulse when a write is dropped
- start  in  1  begin replay from entry 0
- abort  in  1  stop replay, return to IDLE
- busy  out  1  high in WAIT/FIRE
- done  out  1  one-cycle pulse after the last entry is issued
- count  out  AW+1  entries loaded
- evt_idx  out  AW  index of the entry currently pending
- new_input  out  N_IN  per-channel strobe
- input_data  out  N_IN*DATA_W  channel k at bits [k*DATA_W +: DATA_W]

## Operation
- States: IDLE, WAIT, FIRE. Reset enters IDLE with count=0, evt_idx=0, and every output 0. Memory contents are not reset.
- IDLE:
  - wr_en with count<DEPTH writes mem[count] and increments count.
  - wr_en with count==DEPTH is dropped and pulses wr_err.
  - clr sets count←0. clr together with wr_en: clr wins and the write is dropped, with no wr_err.
  - start with count==0 pulses done and stays in IDLE.
  - start with count>0 sets evt_idx←0, loads the gap counter with mem[0].delta, and goes to WAIT.
- WAIT: the gap counter decrements each enabled cycle. When it reaches 0, the block moves to FIRE.
- FIRE (one cycle):
  - new_input[k] = mask[k] of entry evt_idx; input_data lane k = value k where mask[k]=1, else 0.
  - An all-zero mask is a pure delay entry: no strobe, and it still consumes its delta. Gaps longer than 2^TS_W−1 are built from such entries.
  - If evt_idx == count−1: pulse done in the same cycle the state returns to IDLE (see Timing).
  - Otherwise: increment evt_idx, load the next delta, and go to WAIT, or stay in FIRE if that delta is 0.
- wr_en, clr, or start while busy: ignored. wr_en also pulses wr_err.
- abort (any state): next state IDLE, strobes and data 0, count and memory kept, no done. abort beats start in the same cycle.
- en=0: no state, counter, or memory changes; new_input and input_data are forced 0. A pending FIRE issues on the next enabled cycle.
- Outside FIRE, new_input=0 and input_data=0.

## Timing
- start sampled at edge t → the first strobe is visible in cycle t+1+delta0.
- Strobe of entry i at cycle s → strobe of entry i+1 at cycle s+1+delta(i+1). Delta 0 gives back-to-back strobes.
- done is high in cycle s_last+1; busy falls in that same cycle.
- wr_full and count update one cycle after the accepted write edge.
- All outputs are registered. There is no combinational path from any input to any output.
- rst assertion mid-replay clears strobes asynchronously, without waiting for clk.

## Configuration
- TRACE_REPLAY_LOOP_EN defined:
  - Adds input port `loop` (1 bit), sampled at the last FIRE.
  - With loop=1, the block wraps to entry 0 instead of finishing. delta0 is counted from the last strobe and done is not pulsed.
  - Only abort or rst ends the replay.
- Undefined: the `loop` port is absent and replay is always one-shot.

## Test plan
- Reset: hold rst=0 for 3 cycles → all outputs 0, count=0; release → still idle.
- Load 3 entries (delta 0, mask 3'b111, values 1/1/1), (delta 3, 3'b111, 2), (delta 0, 3'b101, 8); start at edge t → strobes in cycles t+1, t+5, t+6. Third event drives channels 0 and 2 with 8 and channel 1 with 0. done at t+7.
- Write 17 entries into DEPTH=16 → wr_full=1, count=16, 17th write pulses wr_err; start replays exactly 16 events.
- Replay with one all-zero-mask entry of delta 100 between two real events → no strobe for that entry; gap between the two strobes = 100+1+delta_next+1 cycles.
- abort in the cycle after the first strobe of a 4-entry trace → busy=0 next cycle, no further strobes, no done, count=4; a new start replays from entry 0.
- en=0 for 5 cycles during WAIT with gap 2 remaining → strobe lands 5 cycles later than nominal; with TRACE_REPLAY_LOOP_EN and loop=1, a 2-entry trace repeats ≥3 times without done.
